// File: rtl/systolic_pkg.sv
// Shared state encoding, lane types and width helpers
// for the systolic array job sequencer.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } ctrl_state_e;

  localparam int DEF_DIN_WIDTH = 8;
  localparam int DEF_N         = 4;

  typedef logic [DEF_N-1:0][DEF_DIN_WIDTH-1:0]   lane_vec_t;
  typedef logic [DEF_N-1:0][2*DEF_DIN_WIDTH-1:0] res_lane_vec_t;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int res_width(input int din_width);
    return 2 * din_width;
  endfunction

endpackage

// File: rtl/systolic_skew.sv
// Triangular delay line: lane i is delayed i cycles,
// invalid input and cleared stages shift in zeros.
module systolic_skew #(
  parameter int DIN_WIDTH = 8,
  parameter int N         = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          vld,
  input  logic [N-1:0][DIN_WIDTH-1:0]   din,
  output logic [N-1:0][DIN_WIDTH-1:0]   dout
);

  logic [N-1:0][DIN_WIDTH-1:0] din_m;

  assign din_m   = vld ? din : '0;
  assign dout[0] = din_m[0];

  for (genvar i = 1; i < N; i++) begin : g_lane
    logic [i*DIN_WIDTH-1:0] sr_q;
    logic [i*DIN_WIDTH-1:0] sr_d;

    always_comb begin
      sr_d = (sr_q << DIN_WIDTH) | (i*DIN_WIDTH)'(din_m[i]);
      if (clr) begin
        sr_d = '0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sr_q <= '0;
      end else begin
        sr_q <= sr_d;
      end
    end

    assign dout[i] = sr_q[i*DIN_WIDTH-1 -: DIN_WIDTH];
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer: fetches operand slices, skews them into the
// array and captures the row-major result stream into the result RAM.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int DIN_WIDTH = 8,
  parameter int N         = 4,
  parameter int K         = 4,
  parameter int TIMEOUT   = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          op_rd_en,
  output logic [clog2_min1(K)-1:0]      op_rd_addr,
  input  logic [N*DIN_WIDTH-1:0]        a_rd_data,
  input  logic [N*DIN_WIDTH-1:0]        b_rd_data,
  output logic                          in_valid,
  output logic [N-1:0][DIN_WIDTH-1:0]   a,
  output logic [N-1:0][DIN_WIDTH-1:0]   b,
  input  logic                          out_valid,
  input  logic [2*DIN_WIDTH-1:0]        c_dout,
  input  logic [clog2_min1(N)-1:0]      c_dout_idx,
  output logic                          res_we,
  output logic [2*clog2_min1(N)-1:0]    res_addr,
  output logic [2*DIN_WIDTH-1:0]        res_wdata
);

  localparam int KAW = clog2_min1(K);
  localparam int NAW = clog2_min1(N);
  localparam int CW  = clog2_min1(K + N);
  localparam int RCW = clog2_min1(N * N + 1);
  localparam int WW  = clog2_min1(TIMEOUT);
  localparam int RW  = res_width(DIN_WIDTH);

  ctrl_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [RCW-1:0]   res_cnt_q, res_cnt_d;
  logic [NAW-1:0]   row_q, row_d;
  logic             err_q, err_d;
  logic             rd_vld_q, rd_vld_d;
  logic             res_we_q, res_we_d;
  logic [2*NAW-1:0] res_addr_q, res_addr_d;
  logic [RW-1:0]    res_wdata_q, res_wdata_d;

  logic                        cap;
  logic                        skew_clr;
  logic [N-1:0][DIN_WIDTH-1:0] a_sk;
  logic [N-1:0][DIN_WIDTH-1:0] b_sk;

  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign err        = err_q;
  assign op_rd_en   = (state_q == FEED) && (cnt_q < CW'(K));
  assign op_rd_addr = op_rd_en ? cnt_q[KAW-1:0] : '0;
  assign in_valid   = (state_q == FEED) && (cnt_q != '0);
  assign a          = (state_q == FEED) ? a_sk : '0;
  assign b          = (state_q == FEED) ? b_sk : '0;
  assign res_we     = res_we_q;
  assign res_addr   = res_addr_q;
  assign res_wdata  = res_wdata_q;

  // Results may arrive while still feeding; beats past N*N are dropped.
  assign cap = ((state_q == FEED) || (state_q == DRAIN))
            && out_valid && (res_cnt_q != RCW'(N * N));

  assign skew_clr = (state_q == IDLE) || abort;
  assign rd_vld_d = op_rd_en && !abort;

  systolic_skew #(
    .DIN_WIDTH (DIN_WIDTH),
    .N         (N)
  ) u_skew_a (
    .clk  (clk),
    .rst  (rst),
    .clr  (skew_clr),
    .vld  (rd_vld_q),
    .din  (a_rd_data),
    .dout (a_sk)
  );

  systolic_skew #(
    .DIN_WIDTH (DIN_WIDTH),
    .N         (N)
  ) u_skew_b (
    .clk  (clk),
    .rst  (rst),
    .clr  (skew_clr),
    .vld  (rd_vld_q),
    .din  (b_rd_data),
    .dout (b_sk)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = '0;
    err_d       = err_q;
    res_cnt_d   = res_cnt_q;
    row_d       = row_q;
    res_we_d    = 1'b0;
    res_addr_d  = res_addr_q;
    res_wdata_d = res_wdata_q;

    if (cap) begin
      res_we_d    = 1'b1;
      res_addr_d  = {row_q, c_dout_idx};
      res_wdata_d = c_dout;
      res_cnt_d   = res_cnt_q + RCW'(1);
      if (c_dout_idx == NAW'(N - 1)) begin
        row_d = row_q + NAW'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && !abort) begin
          state_d   = FEED;
          err_d     = 1'b0;
          res_cnt_d = '0;
          row_d     = '0;
        end
      end
      FEED: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(K + N - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        wait_d = wait_q + WW'(1);
        if (res_cnt_d == RCW'(N * N)) begin
          state_d = DONE;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over every transition but leaves err untouched.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      cnt_d       = '0;
      wait_d      = '0;
      res_cnt_d   = '0;
      row_d       = '0;
      res_we_d    = 1'b0;
      res_addr_d  = '0;
      res_wdata_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wait_q      <= '0;
      res_cnt_q   <= '0;
      row_q       <= '0;
      err_q       <= 1'b0;
      rd_vld_q    <= 1'b0;
      res_we_q    <= 1'b0;
      res_addr_q  <= '0;
      res_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      res_cnt_q   <= res_cnt_d;
      row_q       <= row_d;
      err_q       <= err_d;
      rd_vld_q    <= rd_vld_d;
      res_we_q    <= res_we_d;
      res_addr_q  <= res_addr_d;
      res_wdata_q <= res_wdata_d;
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl: operand RAM model, scripted
// result stream and a scoreboard of expected result-RAM writes.
module tb_systolic_ctrl;

  localparam int DW  = 8;
  localparam int N   = 4;
  localparam int K   = 4;
  localparam int TMO = 256;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 op_rd_en;
  logic [1:0]           op_rd_addr;
  logic [N*DW-1:0]      a_rd_data;
  logic [N*DW-1:0]      b_rd_data;
  logic                 in_valid;
  logic [N-1:0][DW-1:0] a;
  logic [N-1:0][DW-1:0] b;
  logic                 out_valid;
  logic [2*DW-1:0]      c_dout;
  logic [1:0]           c_dout_idx;
  logic                 res_we;
  logic [3:0]           res_addr;
  logic [2*DW-1:0]      res_wdata;

  logic [DW-1:0]   amem [N][K];
  logic [DW-1:0]   bmem [K][N];
  logic [2*DW-1:0] cmat [N][N];

  int unsigned exp_q[$];
  int unsigned e;
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int we_cnt = 0;

  systolic_ctrl #(
    .DIN_WIDTH (DW),
    .N         (N),
    .K         (K),
    .TIMEOUT   (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .op_rd_en   (op_rd_en),
    .op_rd_addr (op_rd_addr),
    .a_rd_data  (a_rd_data),
    .b_rd_data  (b_rd_data),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .c_dout     (c_dout),
    .c_dout_idx (c_dout_idx),
    .res_we     (res_we),
    .res_addr   (res_addr),
    .res_wdata  (res_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (op_rd_en) begin
      for (int i = 0; i < N; i++) begin
        a_rd_data[i*DW +: DW] <= amem[i][op_rd_addr];
        b_rd_data[i*DW +: DW] <= bmem[op_rd_addr][i];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (res_we === 1'b1) begin
      we_cnt++;
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL res_unexpected observed addr=%0h expected no write",
               res_addr);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("res_addr", 64'(res_addr), 64'(e >> 16));
        chk("res_wdata", 64'(res_wdata), 64'(e & 32'hffff));
      end
    end
  end

  function automatic logic [N*DW-1:0] exp_lanes(input bit is_a,
                                                input int c);
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = c - 1 - i;
      if (k >= 0 && k < K)
        v[i*DW +: DW] = is_a ? amem[i][k] : bmem[k][i];
    end
    return v;
  endfunction

  task automatic load(input int mode);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K; k++) begin
        if (mode == 0) begin
          amem[i][k] = 8'(16 * i + k);
          bmem[k][i] = 8'(32 * k + i + 1);
        end else begin
          amem[i][k] = (i == k) ? 8'd1 : 8'd0;
          bmem[k][i] = 8'(4 * k + i + 1);
        end
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < K; k++) s += int'(amem[i][k]) * int'(bmem[k][j]);
        cmat[i][j] = 16'(s);
      end
  endtask

  // Called on a negedge in IDLE; returns on the first DRAIN negedge.
  task automatic feed(input int abort_at);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_clr_on_start", 64'(err), 64'd0);
    for (int c = 0; c < K + N; c++) begin
      chk("busy_feed", 64'(busy), 64'd1);
      chk("in_valid", 64'(in_valid), 64'(c != 0));
      chk("op_rd_en", 64'(op_rd_en), 64'(c < K));
      chk("op_rd_addr", 64'(op_rd_addr), 64'((c < K) ? c : 0));
      chk("a_lanes", 64'(a), 64'(exp_lanes(1'b1, c)));
      chk("b_lanes", 64'(b), 64'(exp_lanes(1'b0, c)));
      if (c == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic emit(input int n);
    for (int r = 0; r < n; r++) begin
      out_valid  = 1'b1;
      c_dout     = cmat[(r / N) % N][r % N];
      c_dout_idx = 2'(r % N);
      if (r < N * N)
        exp_q.push_back(32'(r * 65536 + int'(cmat[r / N][r % N])));
      @(negedge clk);
    end
    out_valid = 1'b0;
  endtask

  task automatic run_full(input int mode);
    int d0;
    int w0;
    d0 = done_cnt;
    w0 = we_cnt;
    load(mode);
    feed(-1);
    chk("drain_a_zero", 64'(a), 64'd0);
    chk("drain_in_valid", 64'(in_valid), 64'd0);
    emit(N * N);
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_in_done", 64'(busy), 64'd1);
    chk("err_ok", 64'(err), 64'd0);
    @(negedge clk);
    chk("done_low", 64'(done), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_count", 64'(done_cnt - d0), 64'd1);
    chk("write_count", 64'(we_cnt - w0), 64'(N * N));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int w;
    int d0;
    int w0;
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    out_valid = 1'b0;
    c_dout = '0;
    c_dout_idx = '0;
    a_rd_data = '0;
    b_rd_data = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_op_rd_en", 64'(op_rd_en), 64'd0);
    chk("rst_op_rd_addr", 64'(op_rd_addr), 64'd0);
    chk("rst_in_valid", 64'(in_valid), 64'd0);
    chk("rst_ab", 64'({a, b}), 64'd0);
    chk("rst_res", 64'({res_we, res_addr, res_wdata}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // skew pattern, then identity x ramp
    run_full(0);
    run_full(1);

    // timeout after only 10 results
    feed(-1);
    emit(10);
    w = 0;
    while (done !== 1'b1 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("timeout_cycles", 64'(w), 64'(TMO - 10));
    chk("timeout_err", 64'(err), 64'd1);
    @(negedge clk);
    chk("timeout_idle", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    chk("err_sticky", 64'(err), 64'd1);

    // abort in FEED cycle 3, err cleared by the start
    d0 = done_cnt;
    load(0);
    feed(3);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ab", 64'({a, b}), 64'd0);
    chk("abort_in_valid", 64'(in_valid), 64'd0);
    chk("abort_op_rd_en", 64'(op_rd_en), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_still_idle", 64'(busy), 64'd0);
    run_full(1);

    // start during DRAIN, surplus beats, out_valid in IDLE
    d0 = done_cnt;
    w0 = we_cnt;
    feed(-1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    emit(N * N + 3);
    chk("ign_busy", 64'(busy), 64'd0);
    out_valid = 1'b1;
    c_dout = 16'hdead;
    c_dout_idx = 2'd0;
    repeat (3) @(negedge clk);
    out_valid = 1'b0;
    @(negedge clk);
    chk("ign_done_count", 64'(done_cnt - d0), 64'd1);
    chk("ign_write_count", 64'(we_cnt - w0), 64'(N * N));
    chk("ign_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("ign_still_idle", 64'(busy), 64'd0);

    // asynchronous reset mid-DRAIN
    w0 = we_cnt;
    feed(-1);
    emit(5);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done_err", 64'({done, err}), 64'd0);
    chk("arst_rd", 64'({op_rd_en, op_rd_addr}), 64'd0);
    chk("arst_feed", 64'({in_valid, a, b}), 64'd0);
    chk("arst_res", 64'({res_we, res_addr, res_wdata}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_no_resume", 64'(busy), 64'd0);
    chk("arst_writes", 64'(we_cnt - w0), 64'd5);
    chk("arst_queue", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
